mul_traffic_master: RTL

- Self-checking initiator for the multiplier valid/ready interface: drives operand pairs on the request channel and collects products on the response channel.
- Checks each product against a signed golden multiply and reports pass/fail counts.
- Sits at the opposite end of the multiplier wrapper's handshake; used as an on-chip BIST driver and as a bench reference initiator.

---
 rtl/mul_traffic_master_pkg.sv | 44 ++++
 rtl/mul_traffic_master_if.sv | 27 ++
 rtl/mul_lfsr32.sv | 27 ++
 rtl/mul_traffic_master.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/mul_traffic_master_pkg.sv
// Shared types and constants for the multiplier traffic master.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state constants, LFSR polynomial, corner-case operand table.
package mul_master_pkg;

    // FSM state encoding (3 bits, kept as plain constants for legacy tools)
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] REQ   = 3'd2;
    localparam logic [2:0] RSP   = 3'd3;
    localparam logic [2:0] CHECK = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    // Galois LFSR feedback mask
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    // The first NUM_CORNERS transactions use fixed operands, the rest come from the LFSR
    localparam int NUM_CORNERS = 4;

    // Operand pair, sign-extended to the widest legal operand (16 bits)
    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
    } opnd_t;

    // Corner operands for index i at the given operand width:
    // 0:(0,0)  1:(-1,-1)  2:(MIN,MIN)  3:(MIN,MAX). Callers take the low width bits.
    function automatic opnd_t corner_operands(input logic [1:0] i, input int width);
        logic [15:0] min_v;
        logic [15:0] max_v;
        opnd_t       r;
        min_v = 16'hFFFF << (width - 1);
        max_v = ~min_v;
        case (i)
            2'd0:    r = '{a: 16'h0000, b: 16'h0000};
            2'd1:    r = '{a: 16'hFFFF, b: 16'hFFFF};
            2'd2:    r = '{a: min_v,    b: min_v};
            default: r = '{a: min_v,    b: max_v};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_traffic_master_if.sv
// Request/response handshake bundle between the traffic master and a multiplier.
// Latency: none (wires only).
// Backpressure: req_ready stalls the request channel, rsp_ready stalls the response channel.
// Ports: req_valid/req_ready/req_a/req_b (operands), rsp_valid/rsp_ready/rsp_data (product).
interface mul_traffic_master_if #(
    parameter int WIDTH = 16
);
    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [2*WIDTH-1:0] rsp_data;

    // Initiator side
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    // Multiplier side
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/mul_lfsr32.sv
// 32-bit Galois LFSR used as the random operand source.
// Latency: new state visible the cycle after load/step.
// Backpressure: none; holds its value when step is low.
// Ports: clk, rst (async high), load+seed (zero seed becomes 1), step, state.
module mul_lfsr32
    import mul_master_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= 32'h1;
        end else if (load) begin
            // the all-zero state is a lock-up state, so never load it
            state <= (seed == 32'h0) ? 32'h1 : seed;
        end else if (step) begin
            state <= {1'b0, state[31:1]} ^ (state[0] ? LFSR_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/mul_traffic_master.sv
// Self-checking initiator: drives operand pairs to a multiplier and checks each product.
// Latency: 4 cycles per transaction minimum (LOAD, REQ, RSP, CHECK); one outstanding.
// Backpressure: waits in REQ for req_ready and in RSP for rsp_valid (watchdog optional).
// Ports: clk, rst (async high), start/num_ops/seed (run control), bus (master modport),
//        busy/done/pass_count/err_count/timeout (status).
// Build option: define MULM_TIMEOUT_EN to enable the response watchdog.
module mul_traffic_master
    import mul_master_pkg::*;
#(
    parameter int WIDTH          = 16,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W-1:0]        num_ops,
    input  logic [31:0]             seed,
    mul_traffic_master_if.master    bus,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        pass_count,
    output logic [CNT_W-1:0]        err_count,
    output logic                    timeout
);

    logic [2:0]               state;
    logic [CNT_W-1:0]         ops_q;
    logic [CNT_W-1:0]         idx;
    logic [WIDTH-1:0]         a_q;
    logic [WIDTH-1:0]         b_q;
    logic [2*WIDTH-1:0]       golden;
    logic [2*WIDTH-1:0]       rsp_q;
    logic [31:0]              lfsr;
    logic                     start_ok;
    logic                     lfsr_load;
    logic                     lfsr_step;
    opnd_t                    corner;
    logic [WIDTH-1:0]         a_nxt;
    logic [WIDTH-1:0]         b_nxt;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] prod_nxt;

    // start is honoured only when no run is in progress
    assign start_ok  = start && ((state == IDLE) || (state == DONE));
    assign lfsr_load = start_ok && (num_ops != '0);
    assign lfsr_step = (state == LOAD) && (idx >= CNT_W'(NUM_CORNERS));

    mul_lfsr32 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .load  (lfsr_load),
        .seed  (seed),
        .step  (lfsr_step),
        .state (lfsr)
    );

    // Operand pair for the current index: fixed corners first, then LFSR halves
    always_comb begin
        corner = corner_operands(idx[1:0], WIDTH);
        if (idx < CNT_W'(NUM_CORNERS)) begin
            a_nxt = corner.a[WIDTH-1:0];
            b_nxt = corner.b[WIDTH-1:0];
        end else begin
            a_nxt = lfsr[WIDTH-1:0];
            b_nxt = lfsr[16 +: WIDTH];
        end
        // sign-extend to full product width so the low 2*WIDTH bits are the signed product
        a_ext    = {{WIDTH{a_nxt[WIDTH-1]}}, a_nxt};
        b_ext    = {{WIDTH{b_nxt[WIDTH-1]}}, b_nxt};
        prod_nxt = a_ext * b_ext;
    end

    // Handshake outputs decode straight from state so reset drops them immediately
    assign bus.req_valid = (state == REQ);
    assign bus.rsp_ready = (state == RSP);
    assign bus.req_a     = a_q;
    assign bus.req_b     = b_q;
    assign busy          = (state == LOAD) || (state == REQ) || (state == RSP) || (state == CHECK);
    assign done          = (state == DONE);

`ifdef MULM_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    // no watchdog: the flag is constant 0 (the comparison is always false)
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ops_q      <= '0;
            idx        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            golden     <= '0;
            rsp_q      <= '0;
            pass_count <= '0;
            err_count  <= '0;
`ifdef MULM_TIMEOUT_EN
            timeout    <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        ops_q      <= num_ops;
                        idx        <= '0;
                        pass_count <= '0;
                        err_count  <= '0;
`ifdef MULM_TIMEOUT_EN
                        timeout    <= 1'b0;
`endif
                        state      <= (num_ops == '0) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    a_q    <= a_nxt;
                    b_q    <= b_nxt;
                    golden <= prod_nxt;
                    state  <= REQ;
                end
                REQ: begin
                    if (bus.req_ready) begin
                        state <= RSP;
`ifdef MULM_TIMEOUT_EN
                        wd_cnt <= '0;
`endif
                    end
                end
                RSP: begin
                    if (bus.rsp_valid) begin
                        rsp_q <= bus.rsp_data;
                        state <= CHECK;
                    end
`ifdef MULM_TIMEOUT_EN
                    else if (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
                        // give up on this run: count the lost response and stop
                        timeout   <= 1'b1;
                        err_count <= (err_count == '1) ? err_count : err_count + CNT_W'(1);
                        state     <= DONE;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
`endif
                end
                CHECK: begin
                    if (rsp_q == golden) begin
                        pass_count <= (pass_count == '1) ? pass_count : pass_count + CNT_W'(1);
                    end else begin
                        err_count  <= (err_count == '1) ? err_count : err_count + CNT_W'(1);
                    end
                    if (idx == ops_q - CNT_W'(1)) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + CNT_W'(1);
                        state <= LOAD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
